// File: rtl/mac_sequencer.sv
// Operand-feeding / product-consuming controller wrapped around an 8-bit
// sequential signed multiplier; accumulates a dot product and hands it off.
module mac_sequencer #(
    parameter int ACC_W   = 24,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_a,
    input  logic [7:0]        in_b,
    input  logic              in_last,
    output logic              mult_start,
    output logic [7:0]        mult_a,
    output logic [7:0]        mult_b,
    input  logic [15:0]       mult_product,
    input  logic              mult_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [7:0]        out_count,
    output logic              out_ovf,
    output logic              out_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [1:0]       state;
    logic             last_r;
    logic [WCW-1:0]   wait_cnt;
    logic [ACC_W-1:0] acc;
    logic [7:0]       count;
    logic             ovf;
    logic             err;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_sum;
    logic             add_ovf;
    logic             timed_out;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; the data travels with valid and ready never waits on valid.
    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_DONE);
    assign out_acc   = acc;
    assign out_count = count;
    assign out_ovf   = ovf;
    assign out_err   = err;

    assign prod_ext  = ACC_W'($signed(mult_product));
    assign acc_sum   = acc + prod_ext;
    assign add_ovf   = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                       (acc_sum[ACC_W-1] != acc[ACC_W-1]);
    assign timed_out = (wait_cnt == WCW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_r     <= 1'b0;
            wait_cnt   <= '0;
            mult_start <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            acc        <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    mult_start <= 1'b0;
                    if (in_valid) begin
                        mult_a     <= in_a;
                        mult_b     <= in_b;
                        last_r     <= in_last;
                        mult_start <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // mult_ready here is stale from the previous operation.
                    mult_start <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    mult_start <= 1'b0;
                    wait_cnt   <= wait_cnt + 1'b1;
                    if (mult_ready) begin
                        acc   <= acc_sum;
                        count <= (count == 8'hFF) ? count : count + 8'd1;
                        ovf   <= ovf | add_ovf;
                        state <= last_r ? S_DONE : S_IDLE;
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    mult_start <= 1'b0;
                    if (out_ready) begin
                        acc   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                        err   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: multiplier stub with programmable latency,
// dot-product reference model, and a result scoreboard.
module tb_mac_sequencer;

    localparam int ACC_W   = 24;
    localparam int TIMEOUT = 15;
    localparam int RW      = ACC_W + 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;
    logic             mult_start;
    logic [7:0]       mult_a;
    logic [7:0]       mult_b;
    logic [15:0]      mult_product = 16'h0;
    logic             mult_ready = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_acc;
    logic [7:0]       out_count;
    logic             out_ovf;
    logic             out_err;

    int vectors     = 0;
    int miscompares = 0;
    longint cyc     = 0;
    longint accept_cyc = 0;

    logic [RW-1:0] exp_q[$];
    logic [15:0]   op_q[$];

    mac_sequencer #(.ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_product(mult_product), .mult_ready(mult_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count),
        .out_ovf(out_ovf), .out_err(out_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- multiplier stub (no reset, like the real one) --------
    // delay_next = cycles after the start edge until ready rises; 0 = hang.
    int stub_cnt   = 0;
    int delay_next = 8;
    always @(posedge clk) begin
        if (mult_start) begin
            stub_cnt   <= delay_next;
            mult_ready <= 1'b0;
            if (delay_next == 0)
                mult_product <= 16'($urandom);
            else
                mult_product <= 16'(int'($signed(mult_a)) * int'($signed(mult_b)));
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) mult_ready <= 1'b1;
        end
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_ovf = 1'b0;

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_push(input bit err);
        logic [ACC_W-1:0] av;
        av = m_acc[ACC_W-1:0];
        exp_q.push_back({av, 8'(m_cnt), m_ovf, err});
        model_clear();
    endtask

    // A term whose product arrives after the timeout (or never) ends the dot
    // product with err set and the accumulator untouched.
    task automatic model_term(input logic [7:0] a, input logic [7:0] b,
                              input bit last, input int delay);
        longint p, s, lim;
        logic [ACC_W-1:0] w;
        if (delay == 0 || delay > TIMEOUT - 1) begin
            model_push(1'b1);
            return;
        end
        lim = longint'(1) << (ACC_W - 1);
        p = longint'($signed(a)) * longint'($signed(b));
        s = m_acc + p;
        if (s > lim - 1 || s < -lim) m_ovf = 1'b1;
        w = s[ACC_W-1:0];
        m_acc = longint'($signed(w));
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        if (last) model_push(1'b0);
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input bit last, input int delay);
        int n = 0;
        @(negedge clk);
        while (!in_ready) begin
            // in_valid/in_a/in_b are don't-care outside IDLE
            in_valid = 1'($urandom_range(0, 1));
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
            n++;
            if (n > 300) begin
                check("in_ready_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
        end
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        in_valid   = 1'b1;
        in_a       = a;
        in_b       = b;
        in_last    = last;
        delay_next = delay;
        accept_cyc = cyc;
        op_q.push_back({a, b});
        model_term(a, b, last, delay);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit hold_out  = 1'b0;
    bit prev_start = 1'b0;
    bit idle_next = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
            idle_next  = 1'b0;
        end else begin
            if (mult_start) begin
                check("start_single_cycle", 64'(prev_start), 64'd0);
                if (op_q.size() == 0)
                    check("start_unexpected", 64'd1, 64'd0);
                else
                    check("mult_operands", 64'({mult_a, mult_b}), 64'(op_q.pop_front()));
            end
            prev_start = mult_start;
            if (idle_next) begin
                check("in_ready_after_take", 64'(in_ready), 64'd1);
                idle_next = 1'b0;
            end
            if (out_valid) begin
                check("in_ready_in_done", 64'(in_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    check("result_unexpected", 64'd1, 64'd0);
                    out_ready = 1'b1;
                end else begin
                    check("result", 64'({out_acc, out_count, out_ovf, out_err}), 64'(exp_q[0]));
                    out_ready = hold_out ? 1'b0 : 1'($urandom_range(0, 2) == 0);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        idle_next = 1'b1;
                    end
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got %0d cycles, expected fewer", cyc);
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int len;
        int d;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mult_start", 64'(mult_start), 64'd0);
        check("rst_mult_ab", 64'({mult_a, mult_b}), 64'd0);
        check("rst_acc", 64'(out_acc), 64'd0);
        rst = 1'b0;
        #1 check("rel_in_ready", 64'(in_ready), 64'd1);

        // single term, latency and hold-off of the result
        hold_out = 1'b1;
        send(8'd3, 8'd5, 1'b1, 8);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("single_latency", 64'(cyc - accept_cyc), 64'd11);
        repeat (10) @(negedge clk);
        hold_out = 1'b0;
        drain();

        // four-term dot product: 15 - 15 + 16384 - 127
        send(8'd3, 8'd5, 1'b0, 8);
        send(8'hFD, 8'd5, 1'b0, 8);
        send(8'h80, 8'h80, 1'b0, 8);
        send(8'd127, 8'hFF, 1'b1, 8);
        drain();

        // hung multiplier, then the next dot product starts clean
        send(8'd4, 8'd4, 1'b0, 8);
        send(8'd9, 8'd9, 1'b0, 0);
        drain();
        send(8'd1, 8'd1, 1'b1, 8);
        // ready on the very timeout cycle wins; one cycle later is an error
        send(8'd2, 8'd3, 1'b1, TIMEOUT - 1);
        send(8'd2, 8'd3, 1'b1, TIMEOUT);
        drain();

        // asynchronous reset in the middle of WAIT
        send(8'd6, 8'd7, 1'b0, 8);
        send(8'd5, 8'd5, 1'b0, 8);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_mult_start", 64'(mult_start), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_rel_in_ready", 64'(in_ready), 64'd1);
        send(8'd2, 8'd2, 1'b1, 8);
        drain();

        // long run: signed overflow wrap and term counter saturation
        for (int i = 0; i < 520; i++)
            send(8'h80, 8'h80, (i == 519), 8);
        drain();

        // randomized dot products
        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++) begin
                case ($urandom_range(0, 11))
                    0:       d = 0;
                    1, 2:    d = $urandom_range(1, TIMEOUT + 1);
                    default: d = 8;
                endcase
                send(8'($urandom), 8'($urandom), (j == len - 1), d);
                if (d == 0 || d > TIMEOUT - 1) break;
            end
        end
        drain();
        check("ops_left", 64'(op_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
